rpn_sequencer: RTL and testbench

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

---
 rtl/rpn_sequencer_pkg.sv | 38 +++
 rtl/rpn_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_sequencer_pkg.sv
// rpn_sequencer_pkg
// Shared constants for the RPN sequencer and anything that talks to it:
//   - ALU opcodes (OP_*)
//   - token type codes (TOK_*)
//   - err_code values (ERR_*)
//   - FSM state enumeration (state_t)
package rpn_sequencer_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] TOK_OPERAND = 2'b00;
  localparam logic [1:0] TOK_ADD     = 2'b01;
  localparam logic [1:0] TOK_MULT    = 2'b10;
  localparam logic [1:0] TOK_END     = 2'b11;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_DEPTH     = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_POP_A,
    S_POP_B,
    S_PUSH_R,
    S_FINAL,
    S_REPORT,
    S_ERROR,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/rpn_sequencer.sv
// rpn_sequencer
// Accepts a stream of RPN tokens and drives an external stack ALU one
// opcode at a time, tracking the ALU stack depth locally.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   tok_valid/type/value      token offer; tok_ready accepts it
//   alu_opcode/input_data     command and push operand to the ALU
//   alu_output_data           ALU result, captured in the WAIT cycle
//   alu_overflow/invalid      ALU status, sampled in the WAIT cycle
//   result_valid/data/error   one-cycle completion pulse and final value
//   err_code                  failure reason, valid with result_valid
//   busy                      high whenever not IDLE
module rpn_sequencer
  import rpn_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  input  logic [1:0]       tok_type,
  input  logic [WIDTH-1:0] tok_value,
  output logic             tok_ready,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input_data,
  input  logic [WIDTH-1:0] alu_output_data,
  input  logic             alu_overflow,
  input  logic             alu_invalid,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_data,
  output logic             result_error,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE        = DW'(1);

  state_t           state_q, state_d;
  state_t           prev_q, prev_d;      // state that issued the opcode WAIT follows
  logic [2:0]       op_q, op_d;          // opcode issued from ISSUE
  logic [WIDTH-1:0] operand_q, operand_d; // push value: token operand or captured ALU result
  logic [WIDTH-1:0] result_q, result_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [1:0]       err_q, err_d;

  assign alu_input_data = operand_q;
  assign result_data    = result_q;
  assign err_code       = err_q;
  assign busy           = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    op_d         = op_q;
    operand_d    = operand_q;
    result_d     = result_q;
    depth_d      = depth_q;
    err_d        = err_q;
    tok_ready    = 1'b0;
    alu_opcode   = OP_NOP;
    result_valid = 1'b0;
    result_error = 1'b0;

    case (state_q)
      S_IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          case (tok_type)
            TOK_OPERAND: begin
              if (depth_q < DEPTH_FULL) begin
                operand_d = tok_value;
                op_d      = OP_PUSH;
                state_d   = S_ISSUE;
              end else begin
                err_d   = ERR_DEPTH;
                state_d = S_ERROR;
              end
            end
            TOK_ADD, TOK_MULT: begin
              if (32'(depth_q) >= 32'd2) begin
                op_d    = (tok_type == TOK_ADD) ? OP_ADD : OP_MULT;
                state_d = S_ISSUE;
              end else begin
                err_d   = ERR_UNDERFLOW;
                state_d = S_ERROR;
              end
            end
            default: begin
              // End token already consumed, so failures go straight to DRAIN.
              if (depth_q == ONE) begin
                state_d = S_FINAL;
              end else if (depth_q == '0) begin
                err_d   = ERR_UNDERFLOW;
                state_d = S_DRAIN;
              end else begin
                err_d   = ERR_DEPTH;
                state_d = S_DRAIN;
              end
            end
          endcase
        end
      end

      S_ISSUE: begin
        alu_opcode = op_q;
        if (op_q == OP_PUSH) depth_d = depth_q + ONE;
        prev_d  = S_ISSUE;
        state_d = S_WAIT;
      end

      S_POP_A: begin
        alu_opcode = OP_POP;
        depth_d    = depth_q - ONE;
        prev_d     = S_POP_A;
        state_d    = S_WAIT;
      end

      S_POP_B: begin
        alu_opcode = OP_POP;
        depth_d    = depth_q - ONE;
        prev_d     = S_POP_B;
        state_d    = S_WAIT;
      end

      S_PUSH_R: begin
        alu_opcode = OP_PUSH;
        depth_d    = depth_q + ONE;
        prev_d     = S_PUSH_R;
        state_d    = S_WAIT;
      end

      S_FINAL: begin
        alu_opcode = OP_POP;
        depth_d    = depth_q - ONE;
        prev_d     = S_FINAL;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (prev_q == S_DRAIN) begin
          // Already failing; drain pops keep the original err_code.
          state_d = S_DRAIN;
        end else if (alu_overflow || alu_invalid) begin
          err_d   = alu_overflow ? ERR_OVERFLOW : ERR_UNDERFLOW;
          state_d = (prev_q == S_FINAL) ? S_DRAIN : S_ERROR;
        end else begin
          case (prev_q)
            S_ISSUE: begin
              if (op_q == OP_PUSH) begin
                state_d = S_IDLE;
              end else begin
                operand_d = alu_output_data; // re-pushed from PUSH_R
                state_d   = S_POP_A;
              end
            end
            S_POP_A:  state_d = S_POP_B;
            S_POP_B:  state_d = S_PUSH_R;
            S_PUSH_R: state_d = S_IDLE;
            S_FINAL: begin
              result_d = alu_output_data;
              state_d  = S_REPORT;
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end

      S_REPORT: begin
        result_valid = 1'b1;
        state_d      = S_IDLE;
      end

      S_ERROR: begin
        tok_ready = 1'b1;
        if (tok_valid && (tok_type == TOK_END)) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (depth_q == '0) begin
          result_valid = 1'b1;
          result_error = 1'b1;
          err_d        = ERR_NONE;
          state_d      = S_IDLE;
        end else begin
          alu_opcode = OP_POP;
          depth_d    = depth_q - ONE;
          prev_d     = S_DRAIN;
          state_d    = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prev_q    <= S_IDLE;
      op_q      <= OP_NOP;
      operand_q <= '0;
      result_q  <= '0;
      depth_q   <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer
// Self-checking bench: behavioural stack ALU, table-driven expressions,
// hand-written corner sequences (opcode traces, mid-expression reset) and
// randomized expressions checked against a queue-based RPN reference model.
module tb_rpn_sequencer;
  import rpn_sequencer_pkg::*;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         tok_valid;
  logic [1:0]   tok_type;
  logic [W-1:0] tok_value;
  logic         tok_ready;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_input_data;
  logic [W-1:0] alu_output_data;
  logic         alu_overflow;
  logic         alu_invalid;
  logic         result_valid;
  logic [W-1:0] result_data;
  logic         result_error;
  logic [1:0]   err_code;
  logic         busy;

  rpn_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_type(tok_type), .tok_value(tok_value), .tok_ready(tok_ready),
    .alu_opcode(alu_opcode), .alu_input_data(alu_input_data), .alu_output_data(alu_output_data),
    .alu_overflow(alu_overflow), .alu_invalid(alu_invalid),
    .result_valid(result_valid), .result_data(result_data), .result_error(result_error),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural stack ALU ----------------
  logic signed [W-1:0] alu_stack[$];
  longint alu_a, alu_b, alu_r;

  always @(posedge clk) begin
    if (rst) begin
      alu_stack.delete();
      alu_output_data <= '0;
      alu_overflow    <= 1'b0;
      alu_invalid     <= 1'b0;
    end else begin
      alu_overflow <= 1'b0;
      alu_invalid  <= 1'b0;
      case (alu_opcode)
        OP_PUSH: alu_stack.push_back(alu_input_data);
        OP_POP: begin
          if (alu_stack.size() > 0) alu_output_data <= alu_stack.pop_back();
          else alu_invalid <= 1'b1;
        end
        OP_ADD, OP_MULT: begin
          if (alu_stack.size() < 2) begin
            alu_invalid <= 1'b1;
          end else begin
            alu_a = longint'(alu_stack[alu_stack.size()-1]);
            alu_b = longint'(alu_stack[alu_stack.size()-2]);
            alu_r = (alu_opcode == OP_ADD) ? alu_a + alu_b : alu_a * alu_b;
            alu_output_data <= alu_r[W-1:0];
            alu_overflow    <= (alu_r != longint'($signed(alu_r[W-1:0])));
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- monitors ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         err;
    logic [1:0]   code;
  } res_t;

  res_t       results[$];
  logic [2:0] trace[$];
  int         viol = 0;
  logic       prev_nz = 1'b0;
  logic       prev_rv = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_nz <= 1'b0;
      prev_rv <= 1'b0;
    end else begin
      if (alu_opcode != OP_NOP) trace.push_back(alu_opcode);
      // back-to-back opcodes, accept-while-issuing, illegal opcodes, long pulses
      if (((alu_opcode != OP_NOP) && prev_nz) ||
          (tok_ready && (alu_opcode != OP_NOP)) ||
          ((alu_opcode != OP_NOP) && (alu_opcode[2] == 1'b0)) ||
          (result_valid && prev_rv))
        viol <= viol + 1;
      if (result_valid) results.push_back('{result_data, result_error, err_code});
      prev_nz <= (alu_opcode != OP_NOP);
      prev_rv <= result_valid;
    end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] typ;
    int         val;
  } tok_t;

  tok_t expr_q[$];

  task automatic add_tok(input logic [1:0] t, input int v);
    expr_q.push_back('{t, v});
  endtask

  // Reference model: evaluates expr_q by RPN rules on a value stack and
  // derives the expected result and the list of ALU commands.
  logic [W-1:0] m_data;
  logic         m_err;
  logic [1:0]   m_code;
  logic [2:0]   m_trace[$];

  function automatic void model();
    longint st[$];
    longint a, b, r;
    int     e = 0;
    m_trace.delete();
    m_data = '0;
    for (int i = 0; i < expr_q.size(); i++) begin
      if (e != 0) begin
        if (expr_q[i].typ == TOK_END) break;
        continue;
      end
      if (expr_q[i].typ == TOK_OPERAND) begin
        if (st.size() == D) e = 3;
        else begin
          st.push_back(longint'(expr_q[i].val));
          m_trace.push_back(OP_PUSH);
        end
      end else if (expr_q[i].typ == TOK_END) begin
        if (st.size() == 1) begin
          m_data = W'(st.pop_back());
          m_trace.push_back(OP_POP);
        end else if (st.size() == 0) e = 2;
        else e = 3;
        break;
      end else begin
        if (st.size() < 2) e = 2;
        else begin
          a = st[st.size()-1];
          b = st[st.size()-2];
          r = (expr_q[i].typ == TOK_ADD) ? a + b : a * b;
          m_trace.push_back((expr_q[i].typ == TOK_ADD) ? OP_ADD : OP_MULT);
          if (r != longint'(int'(r))) e = 1;
          else begin
            void'(st.pop_back());
            void'(st.pop_back());
            st.push_back(longint'(int'(r)));
            m_trace.push_back(OP_POP);
            m_trace.push_back(OP_POP);
            m_trace.push_back(OP_PUSH);
          end
        end
      end
    end
    if (e != 0) for (int k = 0; k < st.size(); k++) m_trace.push_back(OP_POP);
    m_err  = (e != 0);
    m_code = 2'(e);
  endfunction

  task automatic send(input logic [1:0] t, input logic [W-1:0] v);
    int cyc = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type  = t;
    tok_value = v;
    while (!tok_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("tok_ready_wait", tok_ready, 1);
    @(posedge clk);
    #1 tok_valid = 1'b0;
  endtask

  // Sends expr_q, waits for its result and compares it with the given
  // expectations and the ALU command list against the model.
  task automatic run_expr(input string name, input logic [W-1:0] e_data,
                          input logic e_err, input logic [1:0] e_code);
    res_t r;
    int   cyc = 0;
    bit   same;
    trace.delete();
    for (int i = 0; i < expr_q.size(); i++) send(expr_q[i].typ, W'(expr_q[i].val));
    while (results.size() == 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (results.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_result: got no result_valid, expected one within 1000 cycles", name);
      return;
    end
    r = results.pop_front();
    $display("[TB] %s: data=%0d err=%0b code=%0d alu_ops=%0d", name, $signed(r.data), r.err, r.code, trace.size());
    check({name, "_err"}, r.err, e_err);
    check({name, "_code"}, r.code, e_code);
    if (!e_err) check({name, "_data"}, r.data, e_data);
    model();
    same = (trace.size() == m_trace.size());
    for (int i = 0; same && i < trace.size(); i++) if (trace[i] != m_trace[i]) same = 0;
    check({name, "_alu_ops"}, same, 1);
  endtask

  // ---------------- table of expressions ----------------
  typedef struct {
    logic [1:0]   typ;
    int           val;
    logic         e_err;   // expectations used on the end token only
    logic [1:0]   e_code;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic [1:0] t, input int val, input logic ee = 0,
                   input logic [1:0] ec = 0, input int ed = 0);
    vecs.push_back('{t, val, ee, ec, W'(ed)});
  endtask

  logic [2:0] t37[7];
  logic [2:0] t40[2];
  int         cyc_w;
  int         n_expr;

  initial begin
    rst = 1'b1; tok_valid = 1'b0; tok_type = '0; tok_value = '0;
    repeat (3) @(negedge clk);
    check("rst_opcode", alu_opcode, OP_NOP);
    check("rst_input_data", alu_input_data, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_data", result_data, 0);
    check("rst_result_error", result_error, 0);
    check("rst_err_code", err_code, ERR_NONE);
    check("rst_busy", busy, 0);
    check("rst_tok_ready", tok_ready, 1);
    rst = 1'b0;

    // 10 22 + ; -3 -5 * ; overflow ; underflow ; nine operands ; misc
    v(TOK_OPERAND, 10); v(TOK_OPERAND, 22); v(TOK_ADD, 0); v(TOK_END, 0, 0, 0, 32);
    v(TOK_OPERAND, -3); v(TOK_OPERAND, -5); v(TOK_MULT, 0); v(TOK_END, 0, 0, 0, 15);
    v(TOK_OPERAND, 2000000); v(TOK_OPERAND, -1000000); v(TOK_MULT, 0); v(TOK_END, 0, 1, 1);
    v(TOK_OPERAND, 7); v(TOK_ADD, 0); v(TOK_END, 0, 1, 2);
    for (int i = 1; i <= 9; i++) v(TOK_OPERAND, i);
    v(TOK_END, 0, 1, 3);
    v(TOK_END, 0, 1, 2);
    v(TOK_OPERAND, 1); v(TOK_OPERAND, 2); v(TOK_END, 0, 1, 3);
    v(TOK_OPERAND, 32'h7fffffff); v(TOK_OPERAND, 1); v(TOK_ADD, 0); v(TOK_END, 0, 1, 1);
    v(TOK_OPERAND, 2); v(TOK_OPERAND, 3); v(TOK_OPERAND, 4); v(TOK_MULT, 0); v(TOK_ADD, 0); v(TOK_END, 0, 0, 0, 14);
    v(TOK_OPERAND, 5); v(TOK_ADD, 0); v(TOK_OPERAND, 6); v(TOK_MULT, 0); v(TOK_END, 0, 1, 2);
    v(TOK_OPERAND, -7); v(TOK_END, 0, 0, 0, -7);

    n_expr = 0;
    expr_q.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      add_tok(vecs[i].typ, vecs[i].val);
      if (vecs[i].typ == TOK_END) begin
        run_expr($sformatf("table%0d", n_expr), vecs[i].e_data, vecs[i].e_err, vecs[i].e_code);
        expr_q.delete();
        n_expr++;
      end
    end

    // exact command sequence for 10 22 + end
    t37 = '{OP_PUSH, OP_PUSH, OP_ADD, OP_POP, OP_POP, OP_PUSH, OP_POP};
    add_tok(TOK_OPERAND, 10); add_tok(TOK_OPERAND, 22); add_tok(TOK_ADD, 0); add_tok(TOK_END, 0);
    run_expr("seq_add", 32, 0, 0);
    expr_q.delete();
    check("seq_add_len", trace.size(), 7);
    for (int i = 0; i < 7 && i < trace.size(); i++) check($sformatf("seq_add_op%0d", i), trace[i], t37[i]);

    // 7 + end: no add issued, one drain pop
    t40 = '{OP_PUSH, OP_POP};
    add_tok(TOK_OPERAND, 7); add_tok(TOK_ADD, 0); add_tok(TOK_END, 0);
    run_expr("seq_underflow", 0, 1, 2);
    expr_q.delete();
    check("seq_underflow_len", trace.size(), 2);
    for (int i = 0; i < 2 && i < trace.size(); i++) check($sformatf("seq_underflow_op%0d", i), trace[i], t40[i]);

    // reset while waiting on the ALU after an add
    send(TOK_OPERAND, 5);
    send(TOK_OPERAND, 6);
    send(TOK_ADD, 0);
    cyc_w = 0;
    while (alu_opcode != OP_ADD && cyc_w < 50) begin
      @(negedge clk);
      cyc_w++;
    end
    check("rst_mid_saw_add", alu_opcode, OP_ADD);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_opcode", alu_opcode, OP_NOP);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tok_ready", tok_ready, 1);
    check("rst_mid_no_result", results.size(), 0);
    rst = 1'b0;
    add_tok(TOK_OPERAND, 1); add_tok(TOK_OPERAND, 2); add_tok(TOK_ADD, 0); add_tok(TOK_END, 0);
    run_expr("after_rst", 3, 0, 0);
    expr_q.delete();

    // randomized expressions against the reference model
    for (int n = 0; n < 40; n++) begin
      int len = $urandom_range(1, 13);
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 9);
        int val = ($urandom_range(0, 3) == 0) ? int'($urandom) : $urandom_range(0, 200) - 100;
        if (r < 6) add_tok(TOK_OPERAND, val);
        else if (r < 8) add_tok(TOK_ADD, 0);
        else add_tok(TOK_MULT, 0);
      end
      add_tok(TOK_END, 0);
      model();
      run_expr($sformatf("rand%0d", n), m_data, m_err, m_code);
      expr_q.delete();
    end

    repeat (3) @(negedge clk);
    check("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
